// File: rtl/fm_eg.sv
// Time-multiplexed ADSR envelope generator: one operator evaluated per op_valid strobe,
// per-operator envelope state held in an internal array, attenuation out one cycle later.
module fm_eg #(
    parameter int NUM_OPS = 36,
    parameter int OPW     = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           sample_tick,
    input  logic           op_valid,
    input  logic [OPW-1:0] op_idx,
    input  logic           op_kon,
    input  logic           op_egt,
    input  logic           op_ksr,
    input  logic [3:0]     op_ar,
    input  logic [3:0]     op_dr,
    input  logic [3:0]     op_rr,
    input  logic [3:0]     op_sl,
    input  logic [5:0]     op_tl,
    input  logic [2:0]     ch_block,
    input  logic           ch_fnum_msb,
    output logic           out_valid,
    output logic [OPW-1:0] out_idx,
    output logic [11:0]    out_atten
);

    typedef enum logic [1:0] {
        ST_ATTACK  = 2'd0,
        ST_DECAY   = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } eg_state_t;

    logic [8:0]         r_env   [NUM_OPS];
    eg_state_t          r_state [NUM_OPS];
    logic [NUM_OPS-1:0] r_prev_kon;
    logic [11:0]        r_eg_cnt;

    logic           w_idx_ok;
    logic [OPW-1:0] w_rd_idx;
    logic [3:0]     w_keycode;
    logic [3:0]     w_ksr_off;
    logic [8:0]     w_env_cur;
    eg_state_t      w_st_cur;
    logic           w_pk;
    logic [3:0]     w_rate;
    logic [5:0]     w_reff;
    logic [5:0]     w_ar_eff;
    logic [3:0]     w_hi;
    logic           w_step;
    logic [3:0]     w_inc;
    logic [9:0]     w_dec;
    logic [9:0]     w_up;
    logic [8:0]     w_sl_env;
    logic [8:0]     w_env_nxt;
    eg_state_t      w_st_nxt;
    logic [9:0]     w_total;
    logic [11:0]    w_atten;

    // Key-scaled effective rate, saturating at 63; rate 0 stays frozen.
    function automatic logic [5:0] rate_eff(input logic [3:0] rate, input logic [3:0] ksr_off);
        logic [6:0] sum;
        sum = {1'b0, rate, 2'b00} + {3'b000, ksr_off};
        if (rate == 4'd0) begin
            rate_eff = 6'd0;
        end else if (sum > 7'd63) begin
            rate_eff = 6'd63;
        end else begin
            rate_eff = sum[5:0];
        end
    endfunction

    // Combinational envelope update for the operator presented this cycle.
    always_comb begin
        w_idx_ok  = (int'(op_idx) < NUM_OPS);
        w_rd_idx  = w_idx_ok ? op_idx : {OPW{1'b0}};
        w_keycode = {ch_block, ch_fnum_msb};
        w_ksr_off = op_ksr ? w_keycode : {2'b00, w_keycode[3:2]};
        w_env_cur = r_env[w_rd_idx];
        w_st_cur  = r_state[w_rd_idx];
        w_pk      = r_prev_kon[w_rd_idx];
        case (w_st_cur)
            ST_ATTACK:  w_rate = op_ar;
            ST_DECAY:   w_rate = op_dr;
            ST_SUSTAIN: w_rate = op_egt ? 4'd0 : op_rr;
            ST_RELEASE: w_rate = op_rr;
            default:    w_rate = op_rr;
        endcase
        w_reff   = rate_eff(w_rate, w_ksr_off);
        w_ar_eff = rate_eff(op_ar, w_ksr_off);
        w_hi     = w_reff[5:2];
        if (w_reff == 6'd0) begin
            w_step = 1'b0;
        end else if (w_hi >= 4'd12) begin
            w_step = 1'b1;
        end else begin
            w_step = ((r_eg_cnt & (12'hFFF >> w_hi)) == 12'd0);
        end
        w_inc    = (w_hi >= 4'd12) ? (4'd1 << (w_hi - 4'd12)) : 4'd1;
        w_dec    = ({4'd0, w_env_cur[8:3]} + 10'd1) * {6'd0, w_inc};
        w_up     = {1'b0, w_env_cur} + {6'd0, w_inc};
        w_sl_env = (op_sl == 4'd15) ? 9'd496 : {1'b0, op_sl, 4'd0};

        w_env_nxt = w_env_cur;
        w_st_nxt  = w_st_cur;
        if (op_kon && !w_pk) begin
            w_st_nxt = ST_ATTACK;
            if (w_ar_eff >= 6'd60) begin
                w_env_nxt = 9'd0;
            end else begin
                w_env_nxt = w_env_cur;
            end
        end else if (!op_kon && w_pk) begin
            w_st_nxt = ST_RELEASE;
        end else if (w_st_cur == ST_ATTACK) begin
            if (w_step) begin
                w_env_nxt = (w_dec >= {1'b0, w_env_cur}) ? 9'd0 : (w_env_cur - w_dec[8:0]);
            end else begin
                w_env_nxt = w_env_cur;
            end
            w_st_nxt = (w_env_nxt == 9'd0) ? ST_DECAY : ST_ATTACK;
        end else begin
            if (w_step) begin
                w_env_nxt = (w_up > 10'd511) ? 9'd511 : w_up[8:0];
            end else begin
                w_env_nxt = w_env_cur;
            end
            // Decay hands over to sustain once the updated level reaches the sustain level.
            if ((w_st_cur == ST_DECAY) && (w_env_nxt >= w_sl_env)) begin
                w_st_nxt = ST_SUSTAIN;
            end else begin
                w_st_nxt = w_st_cur;
            end
        end

        w_total = {1'b0, w_env_nxt} + {2'd0, op_tl, 2'd0};
        if (!w_idx_ok) begin
            w_atten = 12'hFF8;
        end else if (w_total > 10'd511) begin
            w_atten = 12'hFF8;
        end else begin
            w_atten = {w_total[8:0], 3'b000};
        end
    end

    // Envelope state array, global rate counter and registered output stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_OPS; i++) begin
                r_env[i]   <= 9'd511;
                r_state[i] <= ST_RELEASE;
            end
            r_prev_kon <= {NUM_OPS{1'b0}};
            r_eg_cnt   <= 12'd0;
            out_valid  <= 1'b0;
            out_idx    <= {OPW{1'b0}};
            out_atten  <= 12'd0;
        end else begin
            if (sample_tick) begin
                r_eg_cnt <= r_eg_cnt + 12'd1;
            end
            if (op_valid && w_idx_ok) begin
                r_env[w_rd_idx]      <= w_env_nxt;
                r_state[w_rd_idx]    <= w_st_nxt;
                r_prev_kon[w_rd_idx] <= op_kon;
            end
            out_valid <= op_valid;
            if (op_valid) begin
                out_idx   <= op_idx;
                out_atten <= w_atten;
            end
        end
    end

endmodule
